// File: rtl/ball_detector.sv
// Camera front-end and bright-object locator: pixel threshold, per-frame match count and
// bounding box, exposed through an 8-bit SPI slave register map.
module ball_detector #(
    parameter logic [7:0] THRESH = 8'hF0,
    parameter logic [3:0] ID     = 4'hB
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic       apclk,
    input  logic       ahref,
    input  logic       avsync,
    input  logic [7:0] adata,
    output logic       xclk,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       cs,
    output logic       spi_miso,
    output logic [7:0] led,
    output logic       i2c_clk,
    output logic       i2c_sda,
    output logic       busy
);

    // cs idles high, so its synchroniser resets to 1 to avoid a spurious edge
    localparam logic [5:0] SYNC_RST = 6'b000001;
    localparam logic [4:0] PREV_RST = 5'b00001;

    logic [5:0] meta_q, sync_q;
    logic [4:0] prev_q;
    logic [7:0] data_meta_q, data_q;
    logic       xclk_q;

    logic apclk_s, ahref_s, avsync_s, sclk_s, mosi_s, cs_s;
    logic apclk_p, ahref_p, avsync_p, sclk_p, cs_p;
    logic ap_rise_s, hr_rise_s, hr_fall_s, vs_rise_s, vs_fall_s;
    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

    logic        busy_q, busy_d, phase_q, phase_d, match_q, match_d, valid_q, valid_d;
    logic [9:0]  x_q, x_d, minx_q, minx_d, maxx_q, maxx_d;
    logic [8:0]  y_q, y_d, miny_q, miny_d, maxy_q, maxy_d;
    logic [18:0] cnt_q, cnt_d, res_cnt_q, res_cnt_d;
    logic [9:0]  res_minx_q, res_minx_d, res_maxx_q, res_maxx_d;
    logic [8:0]  res_miny_q, res_miny_d, res_maxy_q, res_maxy_d;
    logic        nz_s;

    logic [3:0] bitcnt_q, bitcnt_d, addr_q, addr_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, led_q, led_d, reg_rd_s;
    logic       miso_q, miso_d;

    assign {apclk_s, ahref_s, avsync_s, sclk_s, mosi_s, cs_s} = sync_q;
    assign {apclk_p, ahref_p, avsync_p, sclk_p, cs_p}         = prev_q;

    assign ap_rise_s   = apclk_s & ~apclk_p;
    assign hr_rise_s   = ahref_s & ~ahref_p;
    assign hr_fall_s   = ~ahref_s & ahref_p;
    assign vs_rise_s   = avsync_s & ~avsync_p;
    assign vs_fall_s   = ~avsync_s & avsync_p;
    assign sclk_rise_s = sclk_s & ~sclk_p;
    assign sclk_fall_s = ~sclk_s & sclk_p;
    assign cs_rise_s   = cs_s & ~cs_p;
    assign cs_fall_s   = ~cs_s & cs_p;
    assign nz_s        = (cnt_q != 19'd0);

    assign xclk     = xclk_q;
    assign spi_miso = miso_q;
    assign led      = led_q;
    assign busy     = busy_q;
    assign i2c_clk  = 1'b1;
    assign i2c_sda  = 1'b1;

    // Two-flop synchronisers, a delayed copy for edge detection, and xclk divider
    always_ff @(posedge inclk) begin
        if (rst) begin
            meta_q      <= SYNC_RST;
            sync_q      <= SYNC_RST;
            prev_q      <= PREV_RST;
            data_meta_q <= 8'h00;
            data_q      <= 8'h00;
            xclk_q      <= 1'b0;
        end else begin
            meta_q      <= {apclk, ahref, avsync, spi_clk, spi_mosi, cs};
            sync_q      <= meta_q;
            prev_q      <= {apclk_s, ahref_s, avsync_s, sclk_s, cs_s};
            data_meta_q <= adata;
            data_q      <= data_meta_q;
            xclk_q      <= ~xclk_q;
        end
    end

    // Frame capture: line edges take priority over a coincident pixel-clock edge
    always_comb begin
        busy_d     = busy_q;
        phase_d    = hr_rise_s ? 1'b0 : phase_q;
        match_d    = match_q;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        minx_d     = minx_q;
        maxx_d     = maxx_q;
        miny_d     = miny_q;
        maxy_d     = maxy_q;
        res_cnt_d  = res_cnt_q;
        res_minx_d = res_minx_q;
        res_maxx_d = res_maxx_q;
        res_miny_d = res_miny_q;
        res_maxy_d = res_maxy_q;
        if (vs_fall_s) begin
            busy_d  = 1'b1;
            phase_d = 1'b0;
            x_d     = 10'd0;
            y_d     = 9'd0;
            cnt_d   = 19'd0;
            minx_d  = 10'd1023;
            maxx_d  = 10'd0;
            miny_d  = 9'd511;
            maxy_d  = 9'd0;
        end else if (vs_rise_s && busy_q) begin
            busy_d     = 1'b0;
            valid_d    = 1'b1;
            res_cnt_d  = cnt_q;
            res_minx_d = nz_s ? minx_q : 10'd0;
            res_maxx_d = nz_s ? maxx_q : 10'd0;
            res_miny_d = nz_s ? miny_q : 9'd0;
            res_maxy_d = nz_s ? maxy_q : 9'd0;
        end else if (busy_q && hr_fall_s) begin
            x_d = 10'd0;
            y_d = (y_q == 9'd511) ? y_q : y_q + 9'd1;
        end else if (busy_q && ahref_s && ap_rise_s) begin
            if (!phase_d) begin
                match_d = (data_q >= THRESH);
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                cnt_d   = match_q ? cnt_q + 19'd1 : cnt_q;
                minx_d  = (match_q && (x_q < minx_q)) ? x_q : minx_q;
                maxx_d  = (match_q && (x_q > maxx_q)) ? x_q : maxx_q;
                miny_d  = (match_q && (y_q < miny_q)) ? y_q : miny_q;
                maxy_d  = (match_q && (y_q > maxy_q)) ? y_q : maxy_q;
                x_d     = (x_q == 10'd1023) ? x_q : x_q + 10'd1;
            end
        end else begin
            match_d = match_q;
        end
    end

    // Register map over the latched results
    always_comb begin
        case (addr_q)
            4'h0:    reg_rd_s = {ID, 3'b000, valid_q};
            4'h1:    reg_rd_s = res_cnt_q[7:0];
            4'h2:    reg_rd_s = res_cnt_q[15:8];
            4'h3:    reg_rd_s = {5'b00000, res_cnt_q[18:16]};
            4'h4:    reg_rd_s = res_minx_q[7:0];
            4'h5:    reg_rd_s = {6'b000000, res_minx_q[9:8]};
            4'h6:    reg_rd_s = res_maxx_q[7:0];
            4'h7:    reg_rd_s = {6'b000000, res_maxx_q[9:8]};
            4'h8:    reg_rd_s = res_miny_q[7:0];
            4'h9:    reg_rd_s = {7'b0000000, res_miny_q[8]};
            4'hA:    reg_rd_s = res_maxy_q[7:0];
            4'hB:    reg_rd_s = {7'b0000000, res_maxy_q[8]};
            default: reg_rd_s = 8'h00;
        endcase
    end

    // SPI slave, mode 0: sample on rising spi_clk, shift out on falling
    always_comb begin
        bitcnt_d = bitcnt_q;
        addr_d   = addr_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        led_d    = led_q;
        miso_d   = miso_q;
        if (cs_fall_s) begin
            bitcnt_d = 4'd0;
            tx_d     = reg_rd_s;
            miso_d   = reg_rd_s[7];
        end else if (cs_rise_s) begin
            miso_d = 1'b0;
            addr_d = (bitcnt_q == 4'd8) ? rx_q[3:0] : addr_q;
            led_d  = (bitcnt_q == 4'd8) ? rx_q : led_q;
        end else if (cs_s) begin
            miso_d = 1'b0;
        end else if (sclk_rise_s) begin
            rx_d     = {rx_q[6:0], mosi_s};
            bitcnt_d = (bitcnt_q == 4'hF) ? bitcnt_q : bitcnt_q + 4'd1;
        end else if (sclk_fall_s) begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
        end else begin
            miso_d = miso_q;
        end
    end

    // State registers for capture, results and SPI
    always_ff @(posedge inclk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            phase_q    <= 1'b0;
            match_q    <= 1'b0;
            valid_q    <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 9'd0;
            cnt_q      <= 19'd0;
            minx_q     <= 10'd0;
            maxx_q     <= 10'd0;
            miny_q     <= 9'd0;
            maxy_q     <= 9'd0;
            res_cnt_q  <= 19'd0;
            res_minx_q <= 10'd0;
            res_maxx_q <= 10'd0;
            res_miny_q <= 9'd0;
            res_maxy_q <= 9'd0;
            bitcnt_q   <= 4'd0;
            addr_q     <= 4'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            led_q      <= 8'h00;
            miso_q     <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            phase_q    <= phase_d;
            match_q    <= match_d;
            valid_q    <= valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            minx_q     <= minx_d;
            maxx_q     <= maxx_d;
            miny_q     <= miny_d;
            maxy_q     <= maxy_d;
            res_cnt_q  <= res_cnt_d;
            res_minx_q <= res_minx_d;
            res_maxx_q <= res_maxx_d;
            res_miny_q <= res_miny_d;
            res_maxy_q <= res_maxy_d;
            bitcnt_q   <= bitcnt_d;
            addr_q     <= addr_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            led_q      <= led_d;
            miso_q     <= miso_d;
        end
    end

endmodule

// File: tb/tb_ball_detector.sv
// Bench for ball_detector: small frames and SPI transfers with a behavioural model of
// the frame statistics and register map.
module tb_ball_detector;

    localparam logic [7:0] THRESH = 8'hF0;

    logic       inclk = 1'b0, rst = 1'b1;
    logic       apclk = 1'b0, ahref = 1'b0, avsync = 1'b1;
    logic [7:0] adata = 8'h00;
    logic       spi_clk = 1'b0, spi_mosi = 1'b0, cs = 1'b1;
    logic       xclk, spi_miso, i2c_clk, i2c_sda, busy;
    logic [7:0] led;

    ball_detector #(.THRESH(8'hF0), .ID(4'hB)) dut (
        .inclk(inclk), .rst(rst), .apclk(apclk), .ahref(ahref), .avsync(avsync),
        .adata(adata), .xclk(xclk), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .cs(cs),
        .spi_miso(spi_miso), .led(led), .i2c_clk(i2c_clk), .i2c_sda(i2c_sda), .busy(busy)
    );

    always #5 inclk = ~inclk;

    int checks = 0, errors = 0;
    int cyc_n = 0, evt_cyc = 0;

    // model state
    logic        m_busy = 1'b0, m_valid = 1'b0;
    logic [7:0]  m_led = 8'h00;
    logic [3:0]  m_addr = 4'h0;
    logic [18:0] m_cnt = 19'd0;
    logic [9:0]  m_minx = 10'd0, m_maxx = 10'd0;
    logic [8:0]  m_miny = 9'd0, m_maxy = 9'd0;
    int          f_cnt, f_minx, f_maxx, f_miny, f_maxy;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge inclk);
        #1;
    endtask

    task automatic mark();
        evt_cyc = cyc_n;
    endtask

    function automatic logic [7:0] reg_of(input logic [3:0] a);
        case (a)
            4'h0:    return {4'hB, 3'b000, m_valid};
            4'h1:    return m_cnt[7:0];
            4'h2:    return m_cnt[15:8];
            4'h3:    return {5'b0, m_cnt[18:16]};
            4'h4:    return m_minx[7:0];
            4'h5:    return {6'b0, m_minx[9:8]};
            4'h6:    return m_maxx[7:0];
            4'h7:    return {6'b0, m_maxx[9:8]};
            4'h8:    return m_miny[7:0];
            4'h9:    return {7'b0, m_miny[8]};
            4'hA:    return m_maxy[7:0];
            4'hB:    return {7'b0, m_maxy[8]};
            default: return 8'h00;
        endcase
    endfunction

    // Per-cycle output checks, applied once outputs have had time to settle after an event
    logic rst_prev = 1'b0, xclk_prev = 1'b0;
    always @(negedge inclk) begin
        check8("i2c_clk", {7'd0, i2c_clk}, 8'd1);
        check8("i2c_sda", {7'd0, i2c_sda}, 8'd1);
        if (rst && rst_prev) check8("xclk_in_reset", {7'd0, xclk}, 8'd0);
        else if (!rst && !rst_prev) check8("xclk_toggle", {7'd0, xclk}, {7'd0, ~xclk_prev});
        if (cyc_n - evt_cyc >= 6) begin
            check8("busy", {7'd0, busy}, {7'd0, m_busy});
            check8("led", led, m_led);
            if (cs) check8("miso_idle", {7'd0, spi_miso}, 8'd0);
        end
        rst_prev  <= rst;
        xclk_prev <= xclk;
        cyc_n     <= cyc_n + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        mark();
        cyc(4);
        rst = 1'b0;
        m_busy = 1'b0; m_valid = 1'b0; m_led = 8'h00; m_addr = 4'h0;
        m_cnt = 19'd0; m_minx = 10'd0; m_maxx = 10'd0; m_miny = 9'd0; m_maxy = 9'd0;
        mark();
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input int nbits, output logic [7:0] rd);
        logic [7:0] expv;
        expv = reg_of(m_addr);
        rd = 8'h00;
        cs = 1'b0;
        mark();
        cyc(8);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
            cyc(4);
            if (i < 8) rd[7-i] = spi_miso;
            check8($sformatf("spi_miso_bit%0d", i), {7'd0, spi_miso},
                   {7'd0, (i < 8) ? expv[7-i] : 1'b0});
            spi_clk = 1'b1;
            cyc(8);
            spi_clk = 1'b0;
            cyc(4);
        end
        cyc(4);
        cs = 1'b1;
        mark();
        if (nbits == 8) begin
            m_led  = cmd;
            m_addr = cmd[3:0];
        end
        spi_mosi = 1'b0;
        cyc(8);
    endtask

    function automatic logic [7:0] gen(input int mode, input int b);
        case (mode)
            0:       return 8'(b % 256);
            1:       return 8'h10;
            2:       return ($urandom_range(0, 9) < 3) ? 8'($urandom_range(240, 255))
                                                       : 8'($urandom_range(0, 239));
            default: return (b >= 2040 && (b % 2) == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] d);
        apclk = 1'b0;
        adata = d;
        cyc(4);
        apclk = 1'b1;
        cyc(4);
    endtask

    // One frame: a blanking line that must be ignored, then nl lines of nb bytes
    task automatic run_frame(input int nl, input int nb, input int mode, input int abort_at);
        logic [7:0] d;
        int p, x, y;
        avsync = 1'b1;
        mark();
        cyc(8);
        ahref = 1'b1;
        for (int b = 0; b < 8; b++) send_byte(8'hFF);
        apclk = 1'b0; cyc(4); ahref = 1'b0; cyc(8);
        avsync = 1'b0;
        mark();
        m_busy = 1'b1;
        f_cnt = 0; f_minx = 1023; f_maxx = 0; f_miny = 511; f_maxy = 0;
        cyc(8);
        for (int l = 0; l < nl; l++) begin
            if (l == abort_at) do_reset();
            ahref = 1'b1;
            cyc(4);
            for (int b = 0; b < nb; b++) begin
                d = gen(mode, b);
                send_byte(d);
                if ((b % 2) == 0 && d >= THRESH) begin
                    p = b / 2;
                    x = (p > 1023) ? 1023 : p;
                    y = (l > 511) ? 511 : l;
                    f_cnt++;
                    if (x < f_minx) f_minx = x;
                    if (x > f_maxx) f_maxx = x;
                    if (y < f_miny) f_miny = y;
                    if (y > f_maxy) f_maxy = y;
                end
            end
            apclk = 1'b0; cyc(4); ahref = 1'b0; cyc(8);
        end
        avsync = 1'b1;
        mark();
        if (m_busy) begin
            m_busy  = 1'b0;
            m_valid = 1'b1;
            m_cnt   = 19'(f_cnt);
            m_minx  = (f_cnt != 0) ? 10'(f_minx) : 10'd0;
            m_maxx  = (f_cnt != 0) ? 10'(f_maxx) : 10'd0;
            m_miny  = (f_cnt != 0) ? 9'(f_miny) : 9'd0;
            m_maxy  = (f_cnt != 0) ? 9'(f_maxy) : 9'd0;
        end
        cyc(8);
    endtask

    // Reads registers 0..11 through chained commands and pins them to literals
    task automatic check_regs(input string tag, input logic [95:0] lits);
        logic [7:0] rd;
        spi_xfer(8'h00, 8, rd);
        for (int k = 0; k < 12; k++) begin
            spi_xfer(8'(k + 1), 8, rd);
            check8($sformatf("%s_reg%0d", tag, k), rd, lits[95-8*k -: 8]);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int sel, nb;
        do_reset();
        cyc(20);
        check8("led_reset", led, 8'h00);
        check8("busy_reset", {7'd0, busy}, 8'd0);

        spi_xfer(8'hAA, 8, rd);
        check8("reg0_idle", rd, 8'hB0);
        check8("led_after_AA", led, 8'hAA);
        spi_xfer(8'h55, 8, rd);
        check8("regA_no_frame", rd, 8'h00);
        check8("led_after_55", led, 8'h55);
        spi_xfer(8'h01, 5, rd);
        check8("reg5_partial", rd, 8'h00);
        check8("led_after_5bit", led, 8'h55);
        spi_xfer(8'hF3, 10, rd);
        check8("led_after_10bit", led, 8'h55);

        run_frame(4, 320, 0, -1);
        check_regs("pattern", {8'hB1, 8'h20, 8'h00, 8'h00, 8'h78, 8'h00,
                               8'h7F, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00});
        run_frame(2, 16, 1, -1);
        check_regs("nomatch", {8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        run_frame(1, 2056, 3, -1);
        check_regs("xsat", {8'hB1, 8'h08, 8'h00, 8'h00, 8'hFC, 8'h03,
                            8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00});

        for (int f = 0; f < 4; f++) begin
            nb = 2 * $urandom_range(4, 24);
            run_frame($urandom_range(2, 6), nb, 2, -1);
            for (int t = 0; t < 3; t++) begin
                sel = $urandom_range(0, 4);
                spi_xfer(8'($urandom_range(0, 255)), (sel == 0) ? 5 : (sel == 4) ? 10 : 8, rd);
            end
            spi_xfer(8'h00, 8, rd);
        end

        run_frame(4, 64, 2, 2);
        spi_xfer(8'h00, 8, rd);
        check8("reg0_after_midframe_reset", rd, 8'hB0);
        run_frame(4, 320, 0, -1);
        check_regs("pattern2", {8'hB1, 8'h20, 8'h00, 8'h00, 8'h78, 8'h00,
                                8'h7F, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00});

        cyc(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
